// File: rtl/jpc_pc_pkg.sv
// Shared types and helpers for the jpc fetch PC generator.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

package jpc_pc_pkg;

    localparam int unsigned INSTR_BYTES_DEF = 4;
    localparam int unsigned ALIGN_BITS      = $clog2(INSTR_BYTES_DEF);

    typedef enum logic [2:0] {
        SRC_HOLD = 3'd0,
        SRC_SEQ  = 3'd1,
        SRC_BR   = 3'd2,
        SRC_RET  = 3'd3,
        SRC_TRAP = 3'd4
    } pc_src_t;

    // Clear the low log2(instr_bytes) bits of an address (up to 64 bits wide).
    function automatic logic [63:0] align_addr(input logic [63:0] addr,
                                               input int unsigned instr_bytes);
        logic [63:0] mask;
        mask = 64'(instr_bytes) - 64'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/jpc_ras.sv
// Circular return-address stack: overwrites oldest entry when full.
module jpc_ras
    import jpc_pc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     top_q, top_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             pop_ok;

    // Next-state: push+pop with entries replaces the top in place.
    always_comb begin
        mem_d  = mem_q;
        wp_d   = wp_q;
        cnt_d  = cnt_q;
        pop_ok = pop && (cnt_q != '0);
        if (push && pop_ok) begin
            mem_d[wp_q - PTR_W'(1)] = data;
        end else if (push) begin
            mem_d[wp_q] = data;
            wp_d        = wp_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_ok) begin
            wp_d  = wp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
        top_d   = mem_d[wp_d - PTR_W'(1)];
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wp_q    <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign top   = top_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/jpc_pc_gen.sv
// Fetch PC generator: prioritised trap/return/branch redirects, handshake, RAS.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module jpc_pc_gen
    import jpc_pc_pkg::*;
#(
    parameter int unsigned ADDR_W       = `JPC_ADDRESS_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned INSTR_BYTES  = 4,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_I,
    input  logic              ready_I,
    output logic              valid_O,
    output logic [ADDR_W-1:0] pc_O,
    input  logic              br_taken_I,
    input  logic [ADDR_W-1:0] br_target_I,
    input  logic              trap_I,
    input  logic [ADDR_W-1:0] trap_vec_I,
    input  logic              call_I,
    input  logic [ADDR_W-1:0] ret_addr_I,
    input  logic              ret_I,
    output logic              misalign_O,
    output logic              ras_underflow_O,
    output logic              ras_empty_O
);

    pc_src_t           src_c;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q;
    logic              misalign_q, misalign_d;
    logic              underflow_q, underflow_d;
    logic [ADDR_W-1:0] br_aligned, trap_aligned;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full_unused;
    logic              ras_push, ras_pop;

    assign br_aligned   = ADDR_W'(align_addr(64'(br_target_I), INSTR_BYTES));
    assign trap_aligned = ADDR_W'(align_addr(64'(trap_vec_I), INSTR_BYTES));

    // A trap suppresses any stack activity in the same cycle.
    assign ras_push = en_I && call_I && !trap_I;
    assign ras_pop  = en_I && ret_I && !trap_I && !ras_empty;

    always_comb begin
        src_c       = SRC_HOLD;
        pc_d        = pc_q;
        misalign_d  = 1'b0;
        underflow_d = en_I && ret_I && !trap_I && ras_empty;
        if (trap_I) begin
            src_c = SRC_TRAP;
        end else if (ras_pop) begin
            src_c = SRC_RET;
        end else if (en_I && br_taken_I) begin
            src_c = SRC_BR;
        end else if (en_I && valid_q && ready_I) begin
            src_c = SRC_SEQ;
        end
        case (src_c)
            SRC_TRAP: pc_d = trap_aligned;
            SRC_RET:  pc_d = ras_top;
            SRC_BR: begin
                pc_d       = br_aligned;
                misalign_d = (br_aligned != br_target_I);
            end
            SRC_SEQ:  pc_d = pc_q + ADDR_W'(INSTR_BYTES);
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_VECTOR;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            valid_q     <= 1'b1;
            misalign_q  <= misalign_d;
            underflow_q <= underflow_d;
        end
    end

    jpc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .data  (ret_addr_I),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full_unused)
    );

    assign pc_O            = pc_q;
    assign valid_O         = valid_q;
    assign misalign_O      = misalign_q;
    assign ras_underflow_O = underflow_q;
    assign ras_empty_O     = ras_empty;

endmodule

// File: tb/tb_jpc_pc_gen.sv
// Directed bench for jpc_pc_gen with ADDR_W=16, RESET_VECTOR=0x100.
module tb_jpc_pc_gen;

    localparam int unsigned AW = 16;

    logic          clk;
    logic          rst;
    logic          en_I, ready_I, valid_O;
    logic [AW-1:0] pc_O;
    logic          br_taken_I;
    logic [AW-1:0] br_target_I;
    logic          trap_I;
    logic [AW-1:0] trap_vec_I;
    logic          call_I;
    logic [AW-1:0] ret_addr_I;
    logic          ret_I;
    logic          misalign_O, ras_underflow_O, ras_empty_O;

    int n_cmp;
    int n_bad;

    jpc_pc_gen #(
        .ADDR_W       (AW),
        .RESET_VECTOR (16'h0100),
        .INSTR_BYTES  (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_I            (en_I),
        .ready_I         (ready_I),
        .valid_O         (valid_O),
        .pc_O            (pc_O),
        .br_taken_I      (br_taken_I),
        .br_target_I     (br_target_I),
        .trap_I          (trap_I),
        .trap_vec_I      (trap_vec_I),
        .call_I          (call_I),
        .ret_addr_I      (ret_addr_I),
        .ret_I           (ret_I),
        .misalign_O      (misalign_O),
        .ras_underflow_O (ras_underflow_O),
        .ras_empty_O     (ras_empty_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        en_I = 1'b1; ready_I = 1'b1;
        br_taken_I = 1'b0; br_target_I = '0;
        trap_I = 1'b0; trap_vec_I = '0;
        call_I = 1'b0; ret_addr_I = '0; ret_I = 1'b0;

        step(); step();
        chk("rst_pc", 32'(pc_O), 32'h100);
        chk("rst_valid", 32'(valid_O), 0);
        chk("rst_empty", 32'(ras_empty_O), 1);
        chk("rst_misalign", 32'(misalign_O), 0);
        chk("rst_underflow", 32'(ras_underflow_O), 0);

        rst = 1'b1;
        step();
        chk("first_pc", 32'(pc_O), 32'h100);
        chk("first_valid", 32'(valid_O), 1);
        step();
        chk("seq_104", 32'(pc_O), 32'h104);
        step();
        chk("seq_108", 32'(pc_O), 32'h108);

        // Stall on ready, then misaligned branch while still stalled
        ready_I = 1'b0;
        step(); chk("stall1", 32'(pc_O), 32'h108);
        step(); chk("stall2", 32'(pc_O), 32'h108);
        step(); chk("stall3", 32'(pc_O), 32'h108);
        br_taken_I = 1'b1; br_target_I = 16'h0202;
        step();
        chk("br_pc", 32'(pc_O), 32'h200);
        chk("br_misalign", 32'(misalign_O), 1);
        br_taken_I = 1'b0; ready_I = 1'b1;
        step();
        chk("br_seq", 32'(pc_O), 32'h204);
        chk("misalign_drop", 32'(misalign_O), 0);

        // Trap overrides the stall and the branch
        en_I = 1'b0; br_taken_I = 1'b1; br_target_I = 16'h0300;
        trap_I = 1'b1; trap_vec_I = 16'h0083;
        step();
        chk("trap_pc", 32'(pc_O), 32'h80);
        chk("trap_no_misalign", 32'(misalign_O), 0);
        trap_I = 1'b0; br_taken_I = 1'b0;
        step();
        chk("en_stall", 32'(pc_O), 32'h80);

        // Five pushes into a four-deep stack
        en_I = 1'b1; call_I = 1'b1;
        ret_addr_I = 16'h0010; step();
        chk("push1_empty", 32'(ras_empty_O), 0);
        chk("push1_pc", 32'(pc_O), 32'h84);
        ret_addr_I = 16'h0020; step();
        ret_addr_I = 16'h0030; step();
        ret_addr_I = 16'h0040; step();
        ret_addr_I = 16'h0050; step();
        chk("push5_pc", 32'(pc_O), 32'h94);
        call_I = 1'b0; ret_I = 1'b1;
        step(); chk("ret1", 32'(pc_O), 32'h50);
        step(); chk("ret2", 32'(pc_O), 32'h40);
        step(); chk("ret3", 32'(pc_O), 32'h30);
        chk("ret3_empty", 32'(ras_empty_O), 0);
        step(); chk("ret4", 32'(pc_O), 32'h20);
        chk("ret4_empty", 32'(ras_empty_O), 1);
        chk("ret4_underflow", 32'(ras_underflow_O), 0);
        step(); chk("ret5_seq", 32'(pc_O), 32'h24);
        chk("ret5_underflow", 32'(ras_underflow_O), 1);
        ret_I = 1'b0;
        step(); chk("after_ret_pc", 32'(pc_O), 32'h28);
        chk("underflow_drop", 32'(ras_underflow_O), 0);

        // Simultaneous call and return replaces the top
        call_I = 1'b1; ret_addr_I = 16'h0010;
        step(); chk("push10_pc", 32'(pc_O), 32'h2C);
        ret_I = 1'b1; ret_addr_I = 16'h0099;
        step();
        chk("callret_pc", 32'(pc_O), 32'h10);
        chk("callret_empty", 32'(ras_empty_O), 0);
        call_I = 1'b0;
        step();
        chk("ret_99", 32'(pc_O), 32'h99);
        chk("ret_99_empty", 32'(ras_empty_O), 1);
        ret_I = 1'b0;

        // Trap suppresses a same-cycle call
        trap_I = 1'b1; trap_vec_I = 16'h0400; call_I = 1'b1; ret_addr_I = 16'h0077;
        step();
        chk("trap_call_pc", 32'(pc_O), 32'h400);
        chk("trap_call_empty", 32'(ras_empty_O), 1);
        trap_I = 1'b0;

        // Branch to top of address space with a push, then wrap
        br_taken_I = 1'b1; br_target_I = 16'hFFFC; ret_addr_I = 16'h0055;
        step();
        chk("br_top_pc", 32'(pc_O), 32'hFFFC);
        chk("br_top_misalign", 32'(misalign_O), 0);
        chk("br_top_empty", 32'(ras_empty_O), 0);
        br_taken_I = 1'b0; call_I = 1'b0;
        step();
        chk("wrap_pc", 32'(pc_O), 32'h0);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("async_pc", 32'(pc_O), 32'h100);
        chk("async_valid", 32'(valid_O), 0);
        chk("async_empty", 32'(ras_empty_O), 1);
        step();
        rst = 1'b1;
        step();
        chk("rerelease_pc", 32'(pc_O), 32'h100);
        chk("rerelease_valid", 32'(valid_O), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
